// File: rtl/regfile_sb_pkg.sv
// Shared constants for the integer register file: default geometry and the
// hardwired-zero register index.
package regfile_sb_pkg;

  localparam int XLEN     = 32;
  localparam int NREGS    = 32;
  localparam int REG_ZERO = 0;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Pending-write scoreboard: one bit per register plus a registered population
// count. Bit 0 never sets; a same-cycle set and clear on one index leaves it set.
module regfile_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter  int NUM = NREGS,
  localparam int AW  = $clog2(NUM)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            set_en,
  input  logic [AW-1:0]   set_idx,
  input  logic            clr_en,
  input  logic [AW-1:0]   clr_idx,
  output logic [NUM-1:0]  pending,
  output logic [AW:0]     pending_cnt
);

  localparam logic [AW-1:0] IDX_ZERO = AW'(REG_ZERO);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);

  logic [NUM-1:0] r_pending;
  logic [AW:0]    r_cnt;
  logic           w_set;
  logic           w_clr;
  logic           w_inc;
  logic           w_dec;

  // Counter moves only when a bit actually changes, so it can neither wrap
  // nor drift from the vector it summarises.
  always_comb begin
    w_set = set_en && (set_idx != IDX_ZERO);
    w_clr = clr_en && (clr_idx != IDX_ZERO) && !(w_set && (set_idx == clr_idx));
    w_inc = w_set && !r_pending[set_idx];
    w_dec = w_clr && r_pending[clr_idx];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pending <= '0;
      r_cnt     <= '0;
    end else begin
      if (w_clr) r_pending[clr_idx] <= 1'b0;
      if (w_set) r_pending[set_idx] <= 1'b1;
      case ({w_inc, w_dec})
        2'b10:   r_cnt <= r_cnt + CNT_ONE;
        2'b01:   r_cnt <= r_cnt - CNT_ONE;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign pending     = r_pending;
  assign pending_cnt = r_cnt;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with one write port, RPORTS combinational read ports,
// optional write-to-read bypass and a pending-write scoreboard for RAW stalls.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter  int WIDTH  = XLEN,
  parameter  int NUM    = NREGS,
  parameter  int RPORTS = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NUM)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    write_en,
  input  logic [AW-1:0]           address_w,
  input  logic [WIDTH-1:0]        data_w,
  input  logic                    issue_en,
  input  logic [AW-1:0]           issue_rd,
  input  logic [RPORTS*AW-1:0]    address_r,
  output logic [RPORTS*WIDTH-1:0] data_r,
  output logic [RPORTS-1:0]       busy_r,
  output logic [AW:0]             pending_cnt
);

  localparam logic [AW-1:0] IDX_ZERO = AW'(REG_ZERO);

  logic [WIDTH-1:0] r_regs [NUM];
  logic [NUM-1:0]   w_pending;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM; i++) r_regs[i] <= '0;
    end else if (write_en && (address_w != IDX_ZERO)) begin
      r_regs[address_w] <= data_w;
    end
  end

  regfile_scoreboard #(
    .NUM (NUM)
  ) u_scoreboard (
    .clock       (clock),
    .reset       (reset),
    .set_en      (issue_en),
    .set_idx     (issue_rd),
    .clr_en      (write_en),
    .clr_idx     (address_w),
    .pending     (w_pending),
    .pending_cnt (pending_cnt)
  );

  // A same-cycle writeback both forwards its data and releases the stall,
  // but only when bypassing is built in.
  for (genvar k = 0; k < RPORTS; k++) begin : g_rd
    logic [AW-1:0] w_addr;
    logic          w_hit;

    assign w_addr = address_r[k*AW +: AW];
    assign w_hit  = (BYPASS != 0) && write_en && (address_w == w_addr);

    assign data_r[k*WIDTH +: WIDTH] = (w_addr == IDX_ZERO) ? '0 :
                                      w_hit               ? data_w :
                                                            r_regs[w_addr];
    assign busy_r[k] = w_pending[w_addr] && !w_hit;
  end

endmodule
